// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_controller_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } control_t;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_DRAIN,
        PC_TRAP
    } pipe_ctrl_state_e;

    localparam int CAUSE_WIDTH = 4;

    localparam logic [CAUSE_WIDTH-1:0] CAUSE_ILLEGAL       = CAUSE_WIDTH'(2);
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_INTERRUPT     = CAUSE_WIDTH'(11);
    localparam logic [CAUSE_WIDTH-1:0] CAUSE_DRAIN_TIMEOUT = CAUSE_WIDTH'(15);

    localparam control_t CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
    localparam control_t CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
    localparam control_t CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_controller_if.sv
// Datapath <-> controller signal bundle; _i/_o are named from the controller's side.
interface pipeline_controller_if;
    import pipeline_controller_pkg::*;

    logic                   interrupt_i;
    logic                   branch_valid_i;
    logic [31:0]            branch_data_i;
    logic                   redirect_ready_i;
    logic [31:0]            fetch_pc_i;
    logic [4:0]             decode_rs1_i;
    logic [4:0]             decode_rs2_i;
    logic                   decode_uses_rs1_i;
    logic                   decode_uses_rs2_i;
    logic                   execute_valid_i;
    logic                   execute_load_i;
    logic [4:0]             execute_rd_i;
    logic                   execute_illegal_i;
    logic [31:0]            execute_pc_i;
    logic                   memory_valid_i;
    logic                   writeback_valid_i;
    logic                   memory_busy_i;
    logic [31:0]            trap_vector_i;

    control_t               fetch_decode_control_o;
    control_t               decode_execute_control_o;
    control_t               execute_memory_control_o;
    control_t               memory_writeback_control_o;
    logic                   redirect_valid_o;
    logic [31:0]            redirect_target_o;
    logic                   trap_taken_o;
    logic [31:0]            trap_pc_o;
    logic [CAUSE_WIDTH-1:0] trap_cause_o;

    modport master (
        output interrupt_i, branch_valid_i, branch_data_i, redirect_ready_i, fetch_pc_i,
               decode_rs1_i, decode_rs2_i, decode_uses_rs1_i, decode_uses_rs2_i,
               execute_valid_i, execute_load_i, execute_rd_i, execute_illegal_i, execute_pc_i,
               memory_valid_i, writeback_valid_i, memory_busy_i, trap_vector_i,
        input  fetch_decode_control_o, decode_execute_control_o, execute_memory_control_o,
               memory_writeback_control_o, redirect_valid_o, redirect_target_o,
               trap_taken_o, trap_pc_o, trap_cause_o
    );

    modport slave (
        input  interrupt_i, branch_valid_i, branch_data_i, redirect_ready_i, fetch_pc_i,
               decode_rs1_i, decode_rs2_i, decode_uses_rs1_i, decode_uses_rs2_i,
               execute_valid_i, execute_load_i, execute_rd_i, execute_illegal_i, execute_pc_i,
               memory_valid_i, writeback_valid_i, memory_busy_i, trap_vector_i,
        output fetch_decode_control_o, decode_execute_control_o, execute_memory_control_o,
               memory_writeback_control_o, redirect_valid_o, redirect_target_o,
               trap_taken_o, trap_pc_o, trap_cause_o
    );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use detector: a load in Execute whose destination is read by the instruction in Decode.
module pipeline_controller_hazard_detect (
    input  logic       execute_valid_i,
    input  logic       execute_load_i,
    input  logic [4:0] execute_rd_i,
    input  logic [4:0] decode_rs1_i,
    input  logic [4:0] decode_rs2_i,
    input  logic       decode_uses_rs1_i,
    input  logic       decode_uses_rs2_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = decode_uses_rs1_i && (decode_rs1_i == execute_rd_i);
    assign rs2_hit    = decode_uses_rs2_i && (decode_rs2_i == execute_rd_i);
    assign load_use_o = execute_valid_i && execute_load_i && (execute_rd_i != 5'd0)
                        && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/sequencing unit: boundary stall/flush, redirect arbitration and trap entry FSM.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int DRAIN_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_controller_if.slave bus
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    pipe_ctrl_state_e       state_q, state_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [31:0]            pend_target_q, pend_target_d;
    logic                   squash_q, squash_d;
    logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic [31:0]            trap_pc_q, trap_pc_d;
    logic [CAUSE_WIDTH-1:0] trap_cause_q, trap_cause_d;
    logic                   trap_pulse_q, trap_pulse_d;

    logic        load_use;
    logic        illegal;
    logic        trap_req;
    logic        drained;
    logic        branch_held;
    logic        redirect_req;
    logic        redirect_ok;
    logic [31:0] redirect_tgt;
    control_t    back_ctrl;

    pipeline_controller_hazard_detect u_hazard_detect (
        .execute_valid_i   (bus.execute_valid_i),
        .execute_load_i    (bus.execute_load_i),
        .execute_rd_i      (bus.execute_rd_i),
        .decode_rs1_i      (bus.decode_rs1_i),
        .decode_rs2_i      (bus.decode_rs2_i),
        .decode_uses_rs1_i (bus.decode_uses_rs1_i),
        .decode_uses_rs2_i (bus.decode_uses_rs2_i),
        .load_use_o        (load_use)
    );

    assign illegal      = bus.execute_valid_i && bus.execute_illegal_i;
    assign trap_req     = (state_q == PC_RUN) && (bus.interrupt_i || illegal);
    assign drained      = !bus.memory_valid_i && !bus.writeback_valid_i && !bus.memory_busy_i;
    // A branch seen while memory is busy is held back until its flushes can be applied.
    assign branch_held  = bus.memory_busy_i && (bus.branch_valid_i || squash_q);
    assign redirect_req = bus.branch_valid_i || pend_valid_q;
    assign redirect_tgt = bus.branch_valid_i ? bus.branch_data_i : pend_target_q;
    assign redirect_ok  = (state_q == PC_RUN) && !trap_req && redirect_req && !branch_held;
    assign back_ctrl    = bus.memory_busy_i ? CTRL_STALL : CTRL_NONE;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PC_RUN;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            squash_q      <= 1'b0;
            drain_cnt_q   <= '0;
            trap_pc_q     <= '0;
            trap_cause_q  <= '0;
            trap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            squash_q      <= squash_d;
            drain_cnt_q   <= drain_cnt_d;
            trap_pc_q     <= trap_pc_d;
            trap_cause_q  <= trap_cause_d;
            trap_pulse_q  <= trap_pulse_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        squash_d      = squash_q;
        drain_cnt_d   = '0;
        trap_pc_d     = trap_pc_q;
        trap_cause_d  = trap_cause_q;
        trap_pulse_d  = 1'b0;
        unique case (state_q)
            PC_RUN: begin
                if (trap_req) begin
                    state_d      = PC_DRAIN;
                    trap_pc_d    = bus.execute_valid_i ? bus.execute_pc_i : bus.fetch_pc_i;
                    trap_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_INTERRUPT;
                    pend_valid_d = 1'b0;
                    squash_d     = 1'b0;
                end else begin
                    if (bus.branch_valid_i && bus.memory_busy_i) squash_d = 1'b1;
                    else if (!bus.memory_busy_i)                 squash_d = 1'b0;
                    if (redirect_req) begin
                        pend_valid_d  = !(redirect_ok && bus.redirect_ready_i);
                        pend_target_d = redirect_tgt;
                    end
                end
            end
            PC_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drained) begin
                    state_d      = PC_TRAP;
                    trap_pulse_d = 1'b1;
                end else if (drain_cnt_d == CNT_W'(DRAIN_MAX)) begin
                    state_d      = PC_TRAP;
                    trap_cause_d = CAUSE_DRAIN_TIMEOUT;
                    trap_pulse_d = 1'b1;
                end
            end
            PC_TRAP: begin
                if (bus.redirect_ready_i) state_d = PC_RUN;
            end
            default: state_d = PC_RUN;
        endcase
    end

    always_comb begin
        bus.fetch_decode_control_o     = CTRL_NONE;
        bus.decode_execute_control_o   = CTRL_NONE;
        bus.execute_memory_control_o   = CTRL_NONE;
        bus.memory_writeback_control_o = CTRL_NONE;
        bus.redirect_valid_o           = 1'b0;
        bus.redirect_target_o          = '0;
        bus.trap_taken_o               = 1'b0;
        if (rst) begin
            bus.fetch_decode_control_o     = CTRL_FLUSH;
            bus.decode_execute_control_o   = CTRL_FLUSH;
            bus.execute_memory_control_o   = CTRL_FLUSH;
            bus.memory_writeback_control_o = CTRL_FLUSH;
        end else if (state_q == PC_RUN && !trap_req) begin
            if ((bus.branch_valid_i || squash_q) && !bus.memory_busy_i) begin
                bus.fetch_decode_control_o   = CTRL_FLUSH;
                bus.decode_execute_control_o = CTRL_FLUSH;
            end else if (bus.memory_busy_i) begin
                bus.fetch_decode_control_o     = CTRL_STALL;
                bus.decode_execute_control_o   = CTRL_STALL;
                bus.execute_memory_control_o   = CTRL_STALL;
                bus.memory_writeback_control_o = CTRL_STALL;
            end else if (load_use) begin
                bus.fetch_decode_control_o   = CTRL_STALL;
                bus.decode_execute_control_o = CTRL_FLUSH;
            end
            bus.redirect_valid_o  = redirect_ok;
            bus.redirect_target_o = redirect_ok ? redirect_tgt : '0;
        end else begin
            // Trap entry, DRAIN and TRAP all squash the front of the pipe.
            bus.fetch_decode_control_o     = CTRL_FLUSH;
            bus.decode_execute_control_o   = CTRL_FLUSH;
            bus.execute_memory_control_o   = CTRL_FLUSH;
            bus.memory_writeback_control_o = back_ctrl;
            if (state_q == PC_TRAP) begin
                bus.redirect_valid_o  = 1'b1;
                bus.redirect_target_o = bus.trap_vector_i;
                bus.trap_taken_o      = trap_pulse_q;
            end
        end
    end

    assign bus.trap_pc_o    = trap_pc_q;
    assign bus.trap_cause_o = trap_cause_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: each stimulus cycle queues its hand-computed outputs; a monitor compares on the falling edge.
module tb_pipeline_controller;
    import pipeline_controller_pkg::*;

    typedef struct packed {
        logic [7:0]  test;
        logic [7:0]  step;
        logic [7:0]  ctrl;
        logic        rv;
        logic [31:0] rt;
        logic        tt;
        logic [31:0] tpc;
        logic [3:0]  tc;
    } exp_t;

    // Boundary order {F/D, D/E, E/M, M/W}, each {stall, flush}.
    localparam logic [7:0] C_IDLE       = 8'b00_00_00_00;
    localparam logic [7:0] C_RST        = 8'b01_01_01_01;
    localparam logic [7:0] C_STALL_ALL  = 8'b10_10_10_10;
    localparam logic [7:0] C_LOAD_USE   = 8'b10_01_00_00;
    localparam logic [7:0] C_BRANCH     = 8'b01_01_00_00;
    localparam logic [7:0] C_DRAIN      = 8'b01_01_01_00;
    localparam logic [7:0] C_DRAIN_BUSY = 8'b01_01_01_10;
    localparam logic [31:0] TV          = 32'h0000_0800;

    logic clk = 1'b1;
    logic rst;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] cur_test = '0;
    logic [7:0] cur_step = '0;

    pipeline_controller_if bus_if ();

    pipeline_controller #(.DRAIN_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string what, input logic ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s", what);
        end
    endtask

    task automatic idle();
        bus_if.interrupt_i       = 1'b0;
        bus_if.branch_valid_i    = 1'b0;
        bus_if.branch_data_i     = '0;
        bus_if.redirect_ready_i  = 1'b1;
        bus_if.fetch_pc_i        = 32'h0000_0200;
        bus_if.decode_rs1_i      = '0;
        bus_if.decode_rs2_i      = '0;
        bus_if.decode_uses_rs1_i = 1'b0;
        bus_if.decode_uses_rs2_i = 1'b0;
        bus_if.execute_valid_i   = 1'b0;
        bus_if.execute_load_i    = 1'b0;
        bus_if.execute_rd_i      = '0;
        bus_if.execute_illegal_i = 1'b0;
        bus_if.execute_pc_i      = '0;
        bus_if.memory_valid_i    = 1'b0;
        bus_if.writeback_valid_i = 1'b0;
        bus_if.memory_busy_i     = 1'b0;
        bus_if.trap_vector_i     = TV;
    endtask

    task automatic begin_test(input logic [7:0] t);
        cur_test = t;
        cur_step = '0;
    endtask

    task automatic tick(input logic [7:0] ctrl, input logic rv, input logic [31:0] rt,
                        input logic tt, input logic [31:0] tpc, input logic [3:0] tc);
        exp_t e;
        e.test = cur_test;
        e.step = cur_step;
        e.ctrl = ctrl;
        e.rv   = rv;
        e.rt   = rt;
        e.tt   = tt;
        e.tpc  = tpc;
        e.tc   = tc;
        exp_q.push_back(e);
        cur_step = cur_step + 8'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] got_ctrl;
        logic       ok;
        if (exp_q.size() != 0) begin
            e        = exp_q.pop_front();
            got_ctrl = {bus_if.fetch_decode_control_o, bus_if.decode_execute_control_o,
                        bus_if.execute_memory_control_o, bus_if.memory_writeback_control_o};
            ok = (got_ctrl === e.ctrl) && (bus_if.redirect_valid_o === e.rv)
                 && (bus_if.redirect_target_o === e.rt) && (bus_if.trap_taken_o === e.tt)
                 && (bus_if.trap_pc_o === e.tpc) && (bus_if.trap_cause_o === e.tc);
            if (!ok) begin
                $display("  t%0d.s%0d (got/exp) ctrl=%b/%b rv=%b/%b rt=%h/%h tt=%b/%b tpc=%h/%h cause=%0d/%0d",
                         e.test, e.step, got_ctrl, e.ctrl, bus_if.redirect_valid_o, e.rv,
                         bus_if.redirect_target_o, e.rt, bus_if.trap_taken_o, e.tt,
                         bus_if.trap_pc_o, e.tpc, bus_if.trap_cause_o, e.tc);
            end
            check($sformatf("monitor t%0d.s%0d", e.test, e.step), ok);
        end
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset: everything flushed, no redirect, no trap state.
        begin_test(8'd0);
        tick(C_RST, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        check("reset state",
              {bus_if.fetch_decode_control_o, bus_if.decode_execute_control_o,
               bus_if.execute_memory_control_o, bus_if.memory_writeback_control_o} === C_RST
              && bus_if.redirect_valid_o === 1'b0 && bus_if.trap_taken_o === 1'b0
              && bus_if.trap_pc_o === 32'h0 && bus_if.trap_cause_o === 4'd0);
        tick(C_RST, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        rst = 1'b0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);

        // Load-use: one bubble, none for x0, unused operands or non-loads.
        begin_test(8'd1);
        bus_if.execute_valid_i = 1'b1; bus_if.execute_load_i = 1'b1; bus_if.execute_rd_i = 5'd5;
        bus_if.decode_rs1_i = 5'd3; bus_if.decode_uses_rs1_i = 1'b1;
        bus_if.decode_rs2_i = 5'd5; bus_if.decode_uses_rs2_i = 1'b1;
        tick(C_LOAD_USE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_valid_i = 1'b0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_valid_i = 1'b1; bus_if.execute_rd_i = 5'd0;
        bus_if.decode_rs1_i = 5'd0; bus_if.decode_rs2_i = 5'd0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_rd_i = 5'd7; bus_if.decode_rs1_i = 5'd7; bus_if.decode_uses_rs1_i = 1'b0;
        bus_if.decode_rs2_i = 5'd2;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_rd_i = 5'd9; bus_if.decode_rs1_i = 5'd9; bus_if.decode_uses_rs1_i = 1'b1;
        tick(C_LOAD_USE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_load_i = 1'b0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);

        // Branch redirect, including branch winning over a simultaneous load-use.
        begin_test(8'd2);
        idle();
        bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h100;
        tick(C_BRANCH, 1'b1, 32'h100, 1'b0, 32'h0, 4'd0);
        bus_if.branch_valid_i = 1'b0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h120;
        bus_if.execute_valid_i = 1'b1; bus_if.execute_load_i = 1'b1; bus_if.execute_rd_i = 5'd4;
        bus_if.decode_rs1_i = 5'd4; bus_if.decode_uses_rs1_i = 1'b1;
        tick(C_BRANCH, 1'b1, 32'h120, 1'b0, 32'h0, 4'd0);

        // Branch under memoryBusy: held for 3 cycles, flushes and redirect on the 4th.
        begin_test(8'd3);
        idle();
        bus_if.memory_busy_i = 1'b1; bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h200;
        tick(C_STALL_ALL, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.branch_valid_i = 1'b0;
        tick(C_STALL_ALL, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        tick(C_STALL_ALL, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.memory_busy_i = 1'b0;
        tick(C_BRANCH, 1'b1, 32'h200, 1'b0, 32'h0, 4'd0);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);

        // Redirect back-pressure and overwrite of a pending target.
        begin_test(8'd4);
        bus_if.redirect_ready_i = 1'b0; bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h100;
        tick(C_BRANCH, 1'b1, 32'h100, 1'b0, 32'h0, 4'd0);
        bus_if.branch_valid_i = 1'b0;
        tick(C_IDLE, 1'b1, 32'h100, 1'b0, 32'h0, 4'd0);
        bus_if.redirect_ready_i = 1'b1;
        tick(C_IDLE, 1'b1, 32'h100, 1'b0, 32'h0, 4'd0);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.redirect_ready_i = 1'b0; bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h140;
        tick(C_BRANCH, 1'b1, 32'h140, 1'b0, 32'h0, 4'd0);
        bus_if.branch_data_i = 32'h180;
        tick(C_BRANCH, 1'b1, 32'h180, 1'b0, 32'h0, 4'd0);
        bus_if.branch_valid_i = 1'b0; bus_if.redirect_ready_i = 1'b1;
        tick(C_IDLE, 1'b1, 32'h180, 1'b0, 32'h0, 4'd0);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);

        // Illegal instruction: same-cycle branch ignored, 2 DRAIN cycles, trap with back-pressure.
        begin_test(8'd5);
        bus_if.execute_valid_i = 1'b1; bus_if.execute_illegal_i = 1'b1; bus_if.execute_pc_i = 32'h40;
        bus_if.memory_valid_i = 1'b1; bus_if.branch_valid_i = 1'b1; bus_if.branch_data_i = 32'h300;
        tick(C_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        bus_if.execute_valid_i = 1'b0; bus_if.execute_illegal_i = 1'b0; bus_if.branch_valid_i = 1'b0;
        tick(C_DRAIN, 1'b0, 32'h0, 1'b0, 32'h40, 4'd2);
        bus_if.memory_valid_i = 1'b0;
        tick(C_DRAIN, 1'b0, 32'h0, 1'b0, 32'h40, 4'd2);
        bus_if.redirect_ready_i = 1'b0;
        tick(C_DRAIN, 1'b1, TV, 1'b1, 32'h40, 4'd2);
        bus_if.redirect_ready_i = 1'b1;
        tick(C_DRAIN, 1'b1, TV, 1'b0, 32'h40, 4'd2);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h40, 4'd2);

        // Interrupt with memory stuck busy: drain timeout after 15 cycles, cause 15.
        begin_test(8'd6);
        bus_if.interrupt_i = 1'b1; bus_if.memory_busy_i = 1'b1;
        tick(C_DRAIN_BUSY, 1'b0, 32'h0, 1'b0, 32'h40, 4'd2);
        bus_if.interrupt_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(C_DRAIN_BUSY, 1'b0, 32'h0, 1'b0, 32'h200, 4'd11);
        end
        check("drain timeout expired",
              bus_if.trap_cause_o === CAUSE_DRAIN_TIMEOUT && bus_if.trap_taken_o === 1'b1
              && bus_if.redirect_valid_o === 1'b1 && bus_if.redirect_target_o === TV);
        bus_if.redirect_ready_i = 1'b0;
        tick(C_DRAIN_BUSY, 1'b1, TV, 1'b1, 32'h200, 4'd15);
        bus_if.redirect_ready_i = 1'b1; bus_if.memory_busy_i = 1'b0;
        tick(C_DRAIN, 1'b1, TV, 1'b0, 32'h200, 4'd15);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h200, 4'd15);

        // Reset in the middle of DRAIN returns to RUN without a trap pulse.
        begin_test(8'd7);
        bus_if.interrupt_i = 1'b1; bus_if.memory_busy_i = 1'b1; bus_if.fetch_pc_i = 32'h300;
        tick(C_DRAIN_BUSY, 1'b0, 32'h0, 1'b0, 32'h200, 4'd15);
        bus_if.interrupt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(C_DRAIN_BUSY, 1'b0, 32'h0, 1'b0, 32'h300, 4'd11);
        end
        rst = 1'b1;
        tick(C_RST, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        idle();
        tick(C_RST, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        rst = 1'b0;
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        tick(C_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
